// File: rtl/raster_pkg.sv
// raster_pkg: constants and types shared by the rasterizer back end.
//   SCREEN_W / SCREEN_H : visible framebuffer size in pixels
//   FRAC_W              : fractional bits in Q10.6 coordinates
//   FIFO_DEPTH          : pixel buffer entries (power of 2)
//   ADDR_W              : framebuffer address width
//   lin_addr()          : y*SCREEN_W + x built from shifts and adds only
package raster_pkg;

  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;
  localparam int FRAC_W     = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 17;
  localparam int COORD_W    = 16 - FRAC_W;

  localparam logic [COORD_W-1:0] SCREEN_W_C = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] SCREEN_H_C = COORD_W'(SCREEN_H);

  typedef logic [15:0] color_t;      // RGBA5551
  typedef logic [15:0] fix_q10_6_t;  // unsigned Q10.6

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    color_t            color;
  } fb_pixel_t;

  typedef enum logic {
    DS_IDLE,
    DS_SHIFT
  } ds_state_t;

  // Adds y<<b for every set bit b of SCREEN_W (320 -> y<<8 + y<<6), so the
  // row stride costs two adders rather than a multiplier.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [COORD_W-1:0] y,
                                                 input logic [COORD_W-1:0] x);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(x);
    for (int b = 0; b < COORD_W; b++) begin
      if (SCREEN_W_C[b]) acc = acc + (ADDR_W'(y) << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO of fb_pixel_t entries.
//   clk, rst_n      : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data : write request; accepted when not full or popping
//   pop             : remove head entry (ignored when empty)
//   head            : current head entry, visible the cycle after its push
//   empty, full     : occupancy flags
module pixel_fifo
  import raster_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  fb_pixel_t push_data,
  input  logic      pop,
  output fb_pixel_t head,
  output logic      empty,
  output logic      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  fb_pixel_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_acc, pop_acc;

  always_comb begin
    pop_acc  = pop && (count_q != '0);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_acc = push && ((count_q != DEPTH_C) || pop_acc);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_acc);
    count_d  = count_q + (PTR_W + 1)'(push_acc) - (PTR_W + 1)'(pop_acc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_data;
  end

  // Asynchronous read of a tiny array so a pixel pushed at one edge is on
  // the write port in the very next cycle.
  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: deserializes rasterizer pixels, converts Q10.6 coordinates
// to a linear framebuffer address, buffers them and drains to the framebuffer.
//   CLK, RST_N          : clock, synchronous active-low reset
//   VALID, PX, PY, C    : pixel start pulse and three serial LSB-first words
//   DONE                : triangle-complete pulse from the rasterizer
//   FB_WE/ADDR/DATA     : framebuffer write request, held until FB_READY
//   FB_READY            : framebuffer accepts when FB_WE && FB_READY
//   TRI_DONE, TRI_COUNT : triangle retired pulse and wrapping count
//   DROP_OOB            : pulse, completed pixel was off screen
//   OVERFLOW, PROTO_ERR : sticky error flags (FIFO full drop, VALID mid-word)
//   BUSY                : shifting, pixels queued, or a DONE still pending
module fb_pixel_writer
  import raster_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              VALID,
  input  logic              PX,
  input  logic              PY,
  input  logic              C,
  input  logic              DONE,
  output logic              FB_WE,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [15:0]       FB_DATA,
  input  logic              FB_READY,
  output logic              TRI_DONE,
  output logic [15:0]       TRI_COUNT,
  output logic              DROP_OOB,
  output logic              OVERFLOW,
  output logic              PROTO_ERR,
  output logic              BUSY
);

  ds_state_t    state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  fix_q10_6_t   px_q, px_d, py_q, py_d;
  color_t       c_q, c_d;
  logic         done_pend_q, done_pend_d;
  logic [15:0]  tri_count_q, tri_count_d;
  logic         drop_oob_q, drop_oob_d;
  logic         overflow_q, overflow_d;
  logic         proto_err_q, proto_err_d;

  logic         shifting, word_done, proto_hit;
  logic [COORD_W-1:0] x_int, y_int;
  logic         oob, push_req, pop, ovf_hit, tri_fire;
  fb_pixel_t    new_pix, head_pix;
  logic         fifo_empty, fifo_full;

  // Deserializer: state register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Deserializer: next state. VALID on the last bit restarts with no gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DS_IDLE: begin
        if (VALID) begin
          state_d = DS_SHIFT;
          cnt_d   = '0;
        end
      end
      DS_SHIFT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = VALID ? DS_SHIFT : DS_IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Deserializer: outputs
  always_comb begin
    shifting  = (state_q == DS_SHIFT);
    word_done = shifting && (cnt_q == 4'd15);
    proto_hit = shifting && (cnt_q != 4'd15) && VALID;
  end

  // Datapath. The completed word is the shift value including this cycle's
  // bit, so the pixel is pushed at the edge that samples bit 15.
  always_comb begin
    px_d = shifting ? {PX, px_q[15:1]} : px_q;
    py_d = shifting ? {PY, py_q[15:1]} : py_q;
    c_d  = shifting ? {C,  c_q[15:1]}  : c_q;

    x_int    = px_d[15:FRAC_W];
    y_int    = py_d[15:FRAC_W];
    oob      = (x_int >= SCREEN_W_C) || (y_int >= SCREEN_H_C);
    push_req = word_done && !oob;

    new_pix.addr  = lin_addr(y_int, x_int);
    new_pix.color = c_d;

    pop      = !fifo_empty && FB_READY;
    ovf_hit  = push_req && fifo_full && !pop;

    // A DONE seen mid-word waits: the word belongs to the finishing triangle.
    tri_fire    = done_pend_q && !shifting && fifo_empty;
    done_pend_d = DONE || (done_pend_q && !tri_fire);
    tri_count_d = tri_count_q + 16'(tri_fire);

    drop_oob_d  = word_done && oob;
    overflow_d  = overflow_q || ovf_hit;
    proto_err_d = proto_err_q || proto_hit;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      px_q        <= '0;
      py_q        <= '0;
      c_q         <= '0;
      done_pend_q <= 1'b0;
      tri_count_q <= '0;
      drop_oob_q  <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      px_q        <= px_d;
      py_q        <= py_d;
      c_q         <= c_d;
      done_pend_q <= done_pend_d;
      tri_count_q <= tri_count_d;
      drop_oob_q  <= drop_oob_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (push_req),
    .push_data (new_pix),
    .pop       (pop),
    .head      (head_pix),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Address/data are forced to zero when idle so stale storage never shows.
  assign FB_WE     = !fifo_empty;
  assign FB_ADDR   = FB_WE ? head_pix.addr  : '0;
  assign FB_DATA   = FB_WE ? head_pix.color : '0;
  assign TRI_DONE  = tri_fire;
  assign TRI_COUNT = tri_count_q;
  assign DROP_OOB  = drop_oob_q;
  assign OVERFLOW  = overflow_q;
  assign PROTO_ERR = proto_err_q;
  assign BUSY      = shifting || !fifo_empty || done_pend_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: directed scenarios followed by a randomized
// pixel stream, checked against a queue of expected framebuffer writes.
module tb_fb_pixel_writer;

  localparam int W = 320;
  localparam int H = 240;
  localparam int F = 6;

  logic        CLK = 1'b0;
  logic        RST_N, VALID, PX, PY, C, DONE, FB_READY;
  logic        FB_WE, TRI_DONE, DROP_OOB, OVERFLOW, PROTO_ERR, BUSY;
  logic [16:0] FB_ADDR;
  logic [15:0] FB_DATA, TRI_COUNT;

  always #5 CLK = ~CLK;

  fb_pixel_writer dut (
    .CLK(CLK), .RST_N(RST_N), .VALID(VALID), .PX(PX), .PY(PY), .C(C), .DONE(DONE),
    .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_READY(FB_READY),
    .TRI_DONE(TRI_DONE), .TRI_COUNT(TRI_COUNT), .DROP_OOB(DROP_OOB),
    .OVERFLOW(OVERFLOW), .PROTO_ERR(PROTO_ERR), .BUSY(BUSY)
  );

  typedef struct packed {
    logic [16:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;
  int   writes = 0, drops = 0, oob_exp = 0, tri_exp = 0;
  logic rand_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] q(input int i, input int f);
    logic [31:0] t;
    t = (i << F) | (f & 63);
    return t[15:0];
  endfunction

  // Reference model: integer coordinates by truncating the fraction, linear
  // address by plain multiplication; queue the write only if accepted.
  task automatic model_pix(input logic [15:0] px, input logic [15:0] py,
                           input logic [15:0] c, input bit accept);
    int x, y;
    exp_t e;
    x = int'(px) >> F;
    y = int'(py) >> F;
    if (x >= W || y >= H) oob_exp++;
    else if (accept) begin
      e.addr = 17'(y * W + x);
      e.data = c;
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    if (rand_ready) FB_READY = ($urandom_range(0, 3) != 0);
  endtask

  // Drives 16 serial bits; VALID is raised during bit index vbit (-1: never).
  task automatic shift_word(input logic [15:0] px, input logic [15:0] py,
                            input logic [15:0] c, input int vbit);
    for (int i = 0; i < 16; i++) begin
      PX = px[i]; PY = py[i]; C = c[i];
      VALID = (i == vbit);
      cyc();
    end
    VALID = 1'b0;
  endtask

  task automatic send_one(input logic [15:0] px, input logic [15:0] py, input logic [15:0] c);
    model_pix(px, py, c, 1'b1);
    VALID = 1'b1;
    cyc();
    shift_word(px, py, c, -1);
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && (exp_q.size() != 0 || FB_WE === 1'b1); n++) cyc();
  endtask

  // Write monitor: every handshake must match the next expected write, and a
  // stalled request must keep address and data stable.
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (prev_stall) begin
        chk("stall_addr", 32'(FB_ADDR), 32'(prev_addr));
        chk("stall_data", 32'(FB_DATA), 32'(prev_data));
      end
      if (FB_WE && FB_READY) begin
        writes++;
        if (exp_q.size() == 0) chk("unexpected_write", 32'(exp_q.size()), 32'd1);
        else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(FB_ADDR), 32'(mon_e.addr));
          chk("wr_data", 32'(FB_DATA), 32'(mon_e.data));
        end
      end
      if (DROP_OOB === 1'b1) drops++;
      prev_stall = FB_WE && !FB_READY;
      prev_addr  = FB_ADDR;
      prev_data  = FB_DATA;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] px, py, c;
    int hs, w0, x, y, chain;

    RST_N = 1'b0; VALID = 1'b0; PX = 1'b0; PY = 1'b0; C = 1'b0; DONE = 1'b0; FB_READY = 1'b0;
    repeat (3) cyc();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_we", 32'(FB_WE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_tri_count", 32'(TRI_COUNT), 32'd0);
    chk("rst_proto", 32'(PROTO_ERR), 32'd0);

    // 1: basic pixel, held by FB_READY=0 so its timing and content are visible
    cyc();
    send_one(16'h02A0, 16'h0500, 16'hF801);
    @(negedge CLK);
    chk("t1_we_T17", 32'(FB_WE), 32'd1);
    chk("t1_addr", 32'(FB_ADDR), 32'd6410);
    chk("t1_data", 32'(FB_DATA), 32'hF801);
    cyc();
    FB_READY = 1'b1;
    drain(10);
    @(negedge CLK);
    chk("t1_drained", 32'(FB_WE), 32'd0);

    // 2: x = 320 is off screen
    cyc();
    send_one(16'h5000, 16'h0040, 16'h1234);
    @(negedge CLK);
    chk("t2_drop_pulse", 32'(DROP_OOB), 32'd1);
    chk("t2_no_we", 32'(FB_WE), 32'd0);
    cyc();
    @(negedge CLK);
    chk("t2_drop_end", 32'(DROP_OOB), 32'd0);
    chk("t2_fifo_empty", 32'(FB_WE), 32'd0);

    // 3: six back-to-back pixels into a stalled framebuffer
    cyc();
    FB_READY = 1'b0;
    w0 = writes;
    VALID = 1'b1;
    cyc();
    for (int k = 0; k < 6; k++) begin
      px = q(k * 7 + 1, k);
      py = q(k + 3, 63 - k);
      c  = 16'($urandom);
      model_pix(px, py, c, k < 4);
      shift_word(px, py, c, (k < 5) ? 15 : -1);
    end
    @(negedge CLK);
    chk("t3_overflow", 32'(OVERFLOW), 32'd1);
    chk("t3_we_held", 32'(FB_WE), 32'd1);
    chk("t3_head_addr", 32'(FB_ADDR), 32'(exp_q[0].addr));
    chk("t3_queued", 32'(exp_q.size()), 32'd4);
    cyc();
    FB_READY = 1'b1;
    drain(20);
    @(negedge CLK);
    chk("t3_write_count", 32'(writes - w0), 32'd4);
    chk("t3_idle", 32'(FB_WE), 32'd0);

    // 4: DONE while two pixels are queued
    cyc();
    FB_READY = 1'b0;
    VALID = 1'b1;
    cyc();
    px = q(100, 3); py = q(50, 0); c = 16'h0F0F;
    model_pix(px, py, c, 1'b1);
    shift_word(px, py, c, 15);
    px = q(101, 9); py = q(50, 1); c = 16'hABCD;
    model_pix(px, py, c, 1'b1);
    shift_word(px, py, c, -1);
    DONE = 1'b1;
    cyc();
    DONE = 1'b0;
    @(negedge CLK);
    chk("t4_no_early_tri", 32'(TRI_DONE), 32'd0);
    chk("t4_busy", 32'(BUSY), 32'd1);
    cyc();
    FB_READY = 1'b1;
    hs = 0;
    for (int n = 0; n < 20 && hs < 2; n++) begin
      @(negedge CLK);
      if (FB_WE && FB_READY) hs++;
      if (hs < 2) cyc();
    end
    chk("t4_handshakes", 32'(hs), 32'd2);
    chk("t4_tri_not_with_write", 32'(TRI_DONE), 32'd0);
    cyc();
    @(negedge CLK);
    chk("t4_tri_pulse", 32'(TRI_DONE), 32'd1);
    tri_exp++;
    cyc();
    @(negedge CLK);
    chk("t4_tri_one_cycle", 32'(TRI_DONE), 32'd0);
    chk("t4_tri_count", 32'(TRI_COUNT), 32'(tri_exp));
    chk("t4_not_busy", 32'(BUSY), 32'd0);

    // 5: reset at bit 7 of a word
    cyc();
    px = q(5, 0); py = q(5, 0); c = 16'h7777;
    VALID = 1'b1;
    cyc();
    VALID = 1'b0;
    for (int i = 0; i < 7; i++) begin
      PX = px[i]; PY = py[i]; C = c[i];
      cyc();
    end
    RST_N = 1'b0;
    PX = px[7]; PY = py[7]; C = c[7];
    cyc();
    RST_N = 1'b1;
    tri_exp = 0;
    @(negedge CLK);
    chk("t5_we", 32'(FB_WE), 32'd0);
    chk("t5_addr", 32'(FB_ADDR), 32'd0);
    chk("t5_data", 32'(FB_DATA), 32'd0);
    chk("t5_tri_done", 32'(TRI_DONE), 32'd0);
    chk("t5_tri_count", 32'(TRI_COUNT), 32'(tri_exp));
    chk("t5_drop", 32'(DROP_OOB), 32'd0);
    chk("t5_overflow", 32'(OVERFLOW), 32'd0);
    chk("t5_proto", 32'(PROTO_ERR), 32'd0);
    chk("t5_busy", 32'(BUSY), 32'd0);
    for (int i = 8; i < 16; i++) begin
      PX = px[i]; PY = py[i]; C = c[i];
      cyc();
    end
    repeat (20) cyc();
    @(negedge CLK);
    chk("t5_no_write", 32'(FB_WE), 32'd0);
    cyc();
    send_one(q(319, 63), q(239, 63), 16'hBEEF);
    drain(10);
    @(negedge CLK);
    chk("t5_after_reset_written", 32'(exp_q.size()), 32'd0);

    // 6: VALID on bit 15 is a legal restart; VALID on bit 5 is a protocol error
    cyc();
    VALID = 1'b1;
    cyc();
    px = q(0, 0); py = q(0, 0); c = 16'h0001;
    model_pix(px, py, c, 1'b1);
    shift_word(px, py, c, 15);
    px = q(7, 1); py = q(200, 2); c = 16'h8000;
    model_pix(px, py, c, 1'b1);
    shift_word(px, py, c, -1);
    drain(10);
    @(negedge CLK);
    chk("t6_no_proto_bit15", 32'(PROTO_ERR), 32'd0);
    cyc();
    VALID = 1'b1;
    cyc();
    px = q(33, 5); py = q(44, 6); c = 16'h5A5A;
    model_pix(px, py, c, 1'b1);
    shift_word(px, py, c, 5);
    @(negedge CLK);
    chk("t6_proto_bit5", 32'(PROTO_ERR), 32'd1);
    cyc();
    drain(10);
    @(negedge CLK);
    chk("t6_word_written", 32'(exp_q.size()), 32'd0);

    // Random stream with random gaps, chaining and FB_READY
    cyc();
    rand_ready = 1'b1;
    VALID = 1'b1;
    cyc();
    for (int k = 0; k < 24; k++) begin
      x = int'($urandom_range(0, 359));
      y = int'($urandom_range(0, 259));
      px = q(x, int'($urandom_range(0, 63)));
      py = q(y, int'($urandom_range(0, 63)));
      c  = 16'($urandom);
      model_pix(px, py, c, 1'b1);
      chain = (k < 23) ? int'($urandom_range(0, 1)) : 0;
      shift_word(px, py, c, (chain != 0) ? 15 : -1);
      if (chain == 0 && k < 23) begin
        repeat ($urandom_range(0, 3)) cyc();
        VALID = 1'b1;
        cyc();
      end
    end
    drain(200);
    rand_ready = 1'b0;
    FB_READY = 1'b1;
    cyc();
    @(negedge CLK);
    chk("rnd_all_written", 32'(exp_q.size()), 32'd0);
    chk("rnd_drops", 32'(drops), 32'(oob_exp));
    chk("rnd_no_overflow", 32'(OVERFLOW), 32'd0);
    chk("rnd_idle", 32'(BUSY), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
